// File: rtl/mcycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// mcycle_ctrl_if
//
// Groups the signals between the multi-cycle sequencer and its environment.
// The environment is the decode stage, the three execute units and the
// writeback path.
//
//   issue side : issue_valid, division, multiplication, bmcycle, waddr, flush
//   unit side  : div/mul/clm _ready and _result in; div/mul/clm _enable and
//                kill out
//   status     : stall, busy, error
//   writeback  : wb_valid, wb_waddr, wb_data
//
// Modports:
//   slave  - the sequencer (mcycle_ctrl)
//   master - the surrounding pipeline / units (or a testbench)
// ---------------------------------------------------------------------------
interface mcycle_ctrl_if;
    logic        issue_valid;
    logic        division;
    logic        multiplication;
    logic        bmcycle;
    logic [4:0]  waddr;
    logic        flush;

    logic        div_ready;
    logic        mul_ready;
    logic        clm_ready;
    logic [31:0] div_result;
    logic [31:0] mul_result;
    logic [31:0] clm_result;

    logic        div_enable;
    logic        mul_enable;
    logic        clm_enable;
    logic        kill;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_data;
    logic        error;

    modport slave (
        input  issue_valid, division, multiplication, bmcycle, waddr, flush,
        input  div_ready, mul_ready, clm_ready,
        input  div_result, mul_result, clm_result,
        output div_enable, mul_enable, clm_enable, kill,
        output stall, busy, wb_valid, wb_waddr, wb_data, error
    );

    modport master (
        output issue_valid, division, multiplication, bmcycle, waddr, flush,
        output div_ready, mul_ready, clm_ready,
        output div_result, mul_result, clm_result,
        input  div_enable, mul_enable, clm_enable, kill,
        input  stall, busy, wb_valid, wb_waddr, wb_data, error
    );
endinterface

// File: rtl/mcycle_ctrl.sv
// ---------------------------------------------------------------------------
// mcycle_ctrl
//
// Execute-stage sequencer for the multi-cycle units: divider, multiplier and
// carry-less multiplier (bmcycle). It starts one unit per accepted
// instruction, stalls the pipeline until that unit reports ready, then
// presents the result as a one-cycle writeback. A flush discards in-flight
// work and pulses kill to the units.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - mcycle_ctrl_if.slave (issue, unit handshake, writeback, status)
//
// Parameters:
//   MAX_CYCLES - watchdog limit in BUSY cycles (used only with the macro)
//
// Optional feature:
//   MCYCLE_TIMEOUT_EN - when defined, a BUSY-cycle counter aborts an op
//   whose unit never answers. The abort raises error and kill for one cycle.
//   When undefined, error is tied low and BUSY waits indefinitely.
// ---------------------------------------------------------------------------
module mcycle_ctrl #(
    parameter int MAX_CYCLES = 40
) (
    input  logic         clock,
    input  logic         reset,
    mcycle_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] SEL_DIV = 2'd0;
    localparam logic [1:0] SEL_MUL = 2'd1;
    localparam logic [1:0] SEL_CLM = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [1:0]  sel;
    logic [1:0]  sel_next;
    logic [4:0]  waddr_q;
    logic [4:0]  wb_waddr_q;
    logic [31:0] wb_data_q;

    logic        any_op;
    logic        accept;
    logic        sel_ready;
    logic [31:0] sel_result;
    logic        limit_hit;

    // -----------------------------------------------------------------------
    // Accept and unit select
    // -----------------------------------------------------------------------
    assign any_op = bus.division | bus.multiplication | bus.bmcycle;

    // Gating with reset keeps the combinational start pulse low while reset is
    // held, even if decode keeps presenting an instruction.
    assign accept = reset && (state == IDLE) && bus.issue_valid && any_op
                    && !bus.flush;

    // Division has priority over multiplication, and multiplication over bmcycle.
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first,
        // so no path can leave it unassigned and infer a latch.
        sel_next = SEL_CLM;
        if (bus.division)
            sel_next = SEL_DIV;
        else if (bus.multiplication)
            sel_next = SEL_MUL;
    end

    // Only the unit that was started is listened to. Ready pulses from the
    // other units are stale or foreign and are ignored.
    always_comb begin
        sel_ready  = 1'b0;
        sel_result = '0;
        case (sel)
            SEL_DIV: begin
                sel_ready  = bus.div_ready;
                sel_result = bus.div_result;
            end
            SEL_MUL: begin
                sel_ready  = bus.mul_ready;
                sel_result = bus.mul_result;
            end
            SEL_CLM: begin
                sel_ready  = bus.clm_ready;
                sel_result = bus.clm_result;
            end
            default: begin
                sel_ready  = 1'b0;
                sel_result = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
`ifdef MCYCLE_TIMEOUT_EN
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] LAST_BUSY = CW'(MAX_CYCLES - 1);

    logic [CW-1:0] count;

    // count holds the number of BUSY cycles already completed. The limit is
    // reached during the BUSY cycle whose increment would make it MAX_CYCLES.
    // A same-cycle ready or flush takes precedence over the timeout.
    assign limit_hit = (state == BUSY) && (count == LAST_BUSY) && !sel_ready
                       && !bus.flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (accept)
            count <= '0;
        else if (state == BUSY && count != LAST_BUSY)
            count <= count + CW'(1);
    end
`else
    assign limit_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = BUSY;
            end
            BUSY: begin
                if (bus.flush || limit_hit)
                    state_next = IDLE;
                else if (sel_ready)
                    state_next = DONE;
            end
            // The completing instruction retires this cycle. It is still on
            // issue_valid, so nothing is accepted until the state is back in IDLE.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state      <= IDLE;
            sel        <= SEL_DIV;
            waddr_q    <= '0;
            wb_waddr_q <= '0;
            wb_data_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                sel     <= sel_next;
                waddr_q <= bus.waddr;
            end
            // Capture on completion only. Between writebacks the values hold.
            if (state == BUSY && sel_ready && !bus.flush && !limit_hit) begin
                wb_data_q  <= sel_result;
                wb_waddr_q <= waddr_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.div_enable = accept && (sel_next == SEL_DIV);
    assign bus.mul_enable = accept && (sel_next == SEL_MUL);
    assign bus.clm_enable = accept && (sel_next == SEL_CLM);

    assign bus.kill     = (state == BUSY) && (bus.flush || limit_hit);
    assign bus.error    = limit_hit;
    assign bus.stall    = accept || (state == BUSY);
    assign bus.busy     = (state != IDLE);
    assign bus.wb_valid = (state == DONE) && !bus.flush;
    assign bus.wb_waddr = wb_waddr_q;
    assign bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mcycle_ctrl
//
// Directed bench for mcycle_ctrl. A transaction-level model tracks whether an
// op is in flight, which unit owns it and how long it has waited. A compare
// process checks every DUT output against that model on each falling edge.
// Hand-computed literal checks in the stimulus pin the model to the expected
// cycle timing.
// ---------------------------------------------------------------------------
module tb_mcycle_ctrl;

    localparam int MAXC = 8;

    logic clock;
    logic reset;

    mcycle_ctrl_if bus ();

    mcycle_ctrl #(.MAX_CYCLES(MAXC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: one op in flight at most, plus a pending retirement
    // -----------------------------------------------------------------------
    bit          m_inflight;   // unit started, result not yet returned
    bit          m_retire;     // result returned, writeback due this cycle
    int          m_unit;       // 0 div, 1 mul, 2 clm
    logic [4:0]  m_waddr;
    int          m_waited;     // BUSY cycles elapsed so far
    logic [31:0] m_wb_data;
    logic [4:0]  m_wb_waddr;

    bit          e_accept;
    int          e_unit;
    bit          e_done;
    bit          e_timeout;
    bit          e_ready[3];
    logic [31:0] e_result[3];
    bit          timeout_en;

    initial begin
`ifdef MCYCLE_TIMEOUT_EN
        timeout_en = 1'b1;
`else
        timeout_en = 1'b0;
`endif
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_div_en", {31'd0, bus.div_enable}, 0);
            check("rst_mul_en", {31'd0, bus.mul_enable}, 0);
            check("rst_clm_en", {31'd0, bus.clm_enable}, 0);
            check("rst_stall",  {31'd0, bus.stall}, 0);
            check("rst_busy",   {31'd0, bus.busy}, 0);
            check("rst_kill",   {31'd0, bus.kill}, 0);
            check("rst_wbv",    {31'd0, bus.wb_valid}, 0);
            check("rst_wbd",    bus.wb_data, 0);
            check("rst_wba",    {27'd0, bus.wb_waddr}, 0);
            check("rst_err",    {31'd0, bus.error}, 0);
            m_inflight = 0; m_retire = 0; m_unit = 0; m_waddr = 0;
            m_waited = 0; m_wb_data = 0; m_wb_waddr = 0;
        end else begin
            e_ready[0] = bus.div_ready;  e_result[0] = bus.div_result;
            e_ready[1] = bus.mul_ready;  e_result[1] = bus.mul_result;
            e_ready[2] = bus.clm_ready;  e_result[2] = bus.clm_result;

            e_accept = !m_inflight && !m_retire && bus.issue_valid && !bus.flush
                       && (bus.division || bus.multiplication || bus.bmcycle);
            e_unit = bus.division ? 0 : (bus.multiplication ? 1 : 2);
            e_done = m_inflight && e_ready[m_unit];
            e_timeout = timeout_en && m_inflight && !e_done && !bus.flush
                        && (m_waited + 1 == MAXC);

            check("div_enable", {31'd0, bus.div_enable}, {31'd0, e_accept && e_unit == 0});
            check("mul_enable", {31'd0, bus.mul_enable}, {31'd0, e_accept && e_unit == 1});
            check("clm_enable", {31'd0, bus.clm_enable}, {31'd0, e_accept && e_unit == 2});
            check("stall",    {31'd0, bus.stall}, {31'd0, e_accept || m_inflight});
            check("busy",     {31'd0, bus.busy},  {31'd0, m_inflight || m_retire});
            check("kill",     {31'd0, bus.kill},  {31'd0, m_inflight && (bus.flush || e_timeout)});
            check("error",    {31'd0, bus.error}, {31'd0, e_timeout});
            check("wb_valid", {31'd0, bus.wb_valid}, {31'd0, m_retire && !bus.flush});
            check("wb_data",  bus.wb_data, m_wb_data);
            check("wb_waddr", {27'd0, bus.wb_waddr}, {27'd0, m_wb_waddr});

            // advance one clock
            m_retire = 0;
            if (m_inflight) begin
                if (bus.flush || e_timeout) begin
                    m_inflight = 0;
                end else if (e_done) begin
                    m_inflight = 0;
                    m_retire   = 1;
                    m_wb_data  = e_result[m_unit];
                    m_wb_waddr = m_waddr;
                end else begin
                    m_waited++;
                end
            end else if (e_accept) begin
                m_inflight = 1;
                m_unit     = e_unit;
                m_waddr    = bus.waddr;
                m_waited   = 0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 0; bus.division = 0; bus.multiplication = 0;
        bus.bmcycle = 0; bus.waddr = 0; bus.flush = 0;
        bus.div_ready = 0; bus.mul_ready = 0; bus.clm_ready = 0;
    endtask

    task automatic issue(input logic d, input logic m, input logic b,
                         input logic [4:0] wa);
        bus.issue_valid = 1; bus.division = d; bus.multiplication = m;
        bus.bmcycle = b; bus.waddr = wa;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    // -----------------------------------------------------------------------
    // Directed sequences
    // -----------------------------------------------------------------------
    initial begin
        reset = 0;
        idle_inputs();
        bus.div_result = 0; bus.mul_result = 0; bus.clm_result = 0;
        #2;
        check("por_busy",  {31'd0, bus.busy}, 0);
        check("por_wbd",   bus.wb_data, 0);
        tick(); tick();
        reset = 1;
        tick();

        // Divide completion: ready in cycle 34, writeback in cycle 35.
        issue(1, 0, 0, 5'd5);                       // cycle 0
        #1;
        check("t1_div_en_c0", {31'd0, bus.div_enable}, 1);
        check("t1_stall_c0",  {31'd0, bus.stall}, 1);
        for (int c = 1; c <= 33; c++) begin
            tick();
            check("t1_stall_busy", {31'd0, bus.stall}, 1);
            check("t1_en_quiet",   {31'd0, bus.div_enable}, 0);
        end
        tick();                                     // cycle 34
        bus.div_ready = 1; bus.div_result = 32'h0000_0007;
        #1;
        check("t1_stall_c34", {31'd0, bus.stall}, 1);
        tick();                                     // cycle 35
        bus.div_ready = 0; bus.div_result = 32'hFFFF_FFFF;
        #1;
        check("t1_wbv_c35",  {31'd0, bus.wb_valid}, 1);
        check("t1_wba_c35",  {27'd0, bus.wb_waddr}, 5);
        check("t1_wbd_c35",  bus.wb_data, 7);
        check("t1_stall_c35", {31'd0, bus.stall}, 0);
        tick();                                     // cycle 36
        idle_inputs();
        #1;
        check("t1_idle_busy", {31'd0, bus.busy}, 0);
        check("t1_hold_wbd",  bus.wb_data, 7);

        // Priority and foreign ready.
        issue(1, 1, 0, 5'd9);                       // cycle 0
        #1;
        check("t2_div_en", {31'd0, bus.div_enable}, 1);
        check("t2_mul_en", {31'd0, bus.mul_enable}, 0);
        tick(); tick(); tick();                     // cycle 3
        bus.mul_ready = 1; bus.mul_result = 32'h0000_DEAD;
        tick();                                     // cycle 4
        bus.mul_ready = 0;
        #1;
        check("t2_still_busy", {31'd0, bus.busy}, 1);
        check("t2_no_wb",      {31'd0, bus.wb_valid}, 0);
        repeat (6) tick();                          // cycle 10
        bus.div_ready = 1; bus.div_result = 32'h1234_5678;
        tick();                                     // cycle 11
        bus.div_ready = 0;
        #1;
        check("t2_wbv", {31'd0, bus.wb_valid}, 1);
        check("t2_wbd", bus.wb_data, 32'h1234_5678);
        check("t2_wba", {27'd0, bus.wb_waddr}, 9);
        tick();
        idle_inputs();

        // Flush in BUSY, then a late ready in IDLE.
        issue(0, 0, 1, 5'd3);                       // cycle 0
        #1;
        check("t3_clm_en", {31'd0, bus.clm_enable}, 1);
        tick(); tick();                             // cycle 2
        bus.flush = 1;
        #1;
        check("t3_kill", {31'd0, bus.kill}, 1);
        tick();                                     // cycle 3
        idle_inputs();
        #1;
        check("t3_idle", {31'd0, bus.busy}, 0);
        check("t3_kill_off", {31'd0, bus.kill}, 0);
        tick();                                     // cycle 4
        bus.clm_ready = 1; bus.clm_result = 32'hCAFE_0001;
        tick();                                     // cycle 5
        bus.clm_ready = 0;
        #1;
        check("t3_no_wb", {31'd0, bus.wb_valid}, 0);
        check("t3_wbd_hold", bus.wb_data, 32'h1234_5678);

        // Flush in the accept cycle: nothing starts.
        issue(1, 0, 0, 5'd2);
        bus.flush = 1;
        #1;
        check("t3b_no_en", {31'd0, bus.div_enable}, 0);
        check("t3b_no_stall", {31'd0, bus.stall}, 0);
        tick();
        idle_inputs();
        #1;
        check("t3b_idle", {31'd0, bus.busy}, 0);

        // Flush in DONE suppresses the writeback.
        issue(0, 1, 0, 5'd6);                       // cycle 0
        tick();                                     // cycle 1
        bus.mul_ready = 1; bus.mul_result = 32'h0000_0A0A;
        tick();                                     // cycle 2 (DONE)
        idle_inputs();
        bus.flush = 1;
        #1;
        check("t3c_wb_suppr", {31'd0, bus.wb_valid}, 0);
        tick();
        idle_inputs();

        // Back-to-back multiplies with issue_valid held high.
        issue(0, 1, 0, 5'd7);                       // cycle 0
        #1;
        check("t4_mul_en_c0", {31'd0, bus.mul_enable}, 1);
        tick();                                     // cycle 1
        bus.mul_ready = 1; bus.mul_result = 32'h0000_0055;
        tick();                                     // cycle 2
        bus.mul_ready = 0;
        #1;
        check("t4_wbv_c2",    {31'd0, bus.wb_valid}, 1);
        check("t4_wbd_c2",    bus.wb_data, 32'h55);
        check("t4_noacc_c2",  {31'd0, bus.mul_enable}, 0);
        check("t4_stall_c2",  {31'd0, bus.stall}, 0);
        tick();                                     // cycle 3
        bus.waddr = 5'd8;
        #1;
        check("t4_mul_en_c3", {31'd0, bus.mul_enable}, 1);
        tick();                                     // cycle 4
        bus.mul_ready = 1; bus.mul_result = 32'h0000_0066;
        tick();                                     // cycle 5
        idle_inputs();
        #1;
        check("t4_wbv_c5", {31'd0, bus.wb_valid}, 1);
        check("t4_wba_c5", {27'd0, bus.wb_waddr}, 8);
        check("t4_wbd_c5", bus.wb_data, 32'h66);
        tick();

        // Watchdog, or an unbounded wait in the default build.
        issue(1, 0, 0, 5'd11);                      // cycle 0
        tick();                                     // cycle 1
        idle_inputs();
`ifdef MCYCLE_TIMEOUT_EN
        repeat (MAXC - 1) tick();                   // cycle 8
        #1;
        check("t5_error", {31'd0, bus.error}, 1);
        check("t5_kill",  {31'd0, bus.kill}, 1);
        tick();                                     // cycle 9
        #1;
        check("t5_idle",  {31'd0, bus.busy}, 0);
        check("t5_err_off", {31'd0, bus.error}, 0);
`else
        for (int c = 2; c <= 60; c++) begin
            tick();
            check("t5_wait_busy", {31'd0, bus.busy}, 1);
            check("t5_no_error",  {31'd0, bus.error}, 0);
        end
        bus.flush = 1;
        #1;
        check("t5_flush_kill", {31'd0, bus.kill}, 1);
        tick();
        bus.flush = 0;
`endif
        tick();

        // Reset during BUSY, then a fresh accept.
        issue(1, 0, 0, 5'd12);                      // cycle 0
        repeat (5) tick();                          // cycle 5
        reset = 0;
        #1;
        check("t6_busy0",  {31'd0, bus.busy}, 0);
        check("t6_stall0", {31'd0, bus.stall}, 0);
        check("t6_en0",    {31'd0, bus.div_enable}, 0);
        check("t6_kill0",  {31'd0, bus.kill}, 0);
        check("t6_wbd0",   bus.wb_data, 0);
        check("t6_wba0",   {27'd0, bus.wb_waddr}, 0);
        tick();
        reset = 1;
        issue(1, 0, 0, 5'd4);                       // cycle 0 after reset
        #1;
        check("t6_reaccept", {31'd0, bus.div_enable}, 1);
        tick();                                     // cycle 1
        bus.div_ready = 1; bus.div_result = 32'hABCD_0123;
        tick();                                     // cycle 2
        idle_inputs();
        #1;
        check("t6_wbv", {31'd0, bus.wb_valid}, 1);
        check("t6_wbd", bus.wb_data, 32'hABCD_0123);
        check("t6_wba", {27'd0, bus.wb_waddr}, 4);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
